motor_cmd_spi_master: RTL

- SPI initiator that drives the motor-command link consumed by the FPGA's SPI receiver: generates sck, sdi and load, and captures sdo.
- Sends one 16-bit frame per accepted command: motor1 byte first, then motor2. Each byte is {dir, speed[6:0]}, MSB first.
- Used in the bench-bridge / loopback build and by any on-chip controller that commands the motor link.

---
 rtl/motor_cmd_spi_master_pkg.sv | 13 +
 rtl/motor_cmd_spi_master_if.sv | 27 ++
 rtl/motor_cmd_spi_master_timer.sv | 24 ++
 rtl/motor_cmd_spi_master.sv | 139 +++++++++++++
 4 files changed

// File: rtl/motor_cmd_spi_master_pkg.sv
// Types shared by the motor-command SPI master and the FPGA-side receiver.
package motor_spi_pkg;

   localparam int FRAME_W = 16;

   typedef struct packed {
      logic       dir;
      logic [6:0] speed;
   } motor_cmd_t;

   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, TAIL, GAP} spi_state_t;

endpackage

// File: rtl/motor_cmd_spi_master_if.sv
// Command handshake plus SPI pins of the motor link; master = SPI initiator side.
interface motor_cmd_spi_if #(parameter int FRAME_W = motor_spi_pkg::FRAME_W);
   import motor_spi_pkg::*;

   logic               cmd_valid;
   logic               cmd_ready;
   motor_cmd_t         motor1;
   motor_cmd_t         motor2;
   logic               sck;
   logic               sdi;
   logic               load;
   logic               sdo;
   logic [FRAME_W-1:0] rx_data;
   logic               rx_valid;
   logic               busy;

   modport master (
      input  cmd_valid, motor1, motor2, sdo,
      output cmd_ready, sck, sdi, load, rx_data, rx_valid, busy
   );

   modport slave (
      output cmd_valid, motor1, motor2, sdo,
      input  cmd_ready, sck, sdi, load, rx_data, rx_valid, busy
   );

endinterface

// File: rtl/motor_cmd_spi_master_timer.sv
// Half-period timer: ticks on the last of every CLK_DIV enabled cycles; restart zeroes it.
module spi_half_period_timer #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   input  logic en,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)               cnt <= '0;
      else if (restart || tick) cnt <= '0;
      else if (en)              cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/motor_cmd_spi_master.sv
// SPI initiator for the motor-command link: one {motor1,motor2} frame per command.
// Optional periodic resend of the last command when MOTOR_KEEPALIVE_EN is defined.
module motor_cmd_spi_master #(
   parameter int CLK_DIV          = 4,
   parameter int FRAME_W          = motor_spi_pkg::FRAME_W,
   parameter int KEEPALIVE_CYCLES = 4096
) (
   input logic             clk,
   input logic             reset,
   motor_cmd_spi_if.master bus
);
   import motor_spi_pkg::*;

   localparam int BW = $clog2(FRAME_W);

   if (CLK_DIV < 2 || KEEPALIVE_CYCLES < 1) begin : g_bad_param
      $error("motor_cmd_spi_master: CLK_DIV must be >= 2 and KEEPALIVE_CYCLES >= 1");
   end

   spi_state_t         state, next;
   logic [FRAME_W-1:0] tx_sr, rx_sr, frame_src;
   logic [BW-1:0]      bit_cnt;
   logic               ready_q, accept, start, tick, last_bit;

   assign accept   = bus.cmd_valid && bus.cmd_ready;
   assign last_bit = bit_cnt == BW'(FRAME_W - 1);

`ifdef MOTOR_KEEPALIVE_EN
   localparam int KW = $clog2(KEEPALIVE_CYCLES + 1);

   logic [KW-1:0]      idle_cnt;
   logic [FRAME_W-1:0] last_cmd;
   logic               ka_fire;

   // ready is masked on the resend cycle so a command can never race the keepalive start
   assign ka_fire       = (state == IDLE) && (idle_cnt == KW'(KEEPALIVE_CYCLES - 1));
   assign bus.cmd_ready = ready_q && !ka_fire;
   assign start         = accept || ka_fire;
   assign frame_src     = accept ? {bus.motor1, bus.motor2} : last_cmd;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idle_cnt <= '0;
         last_cmd <= '0;
      end else begin
         if (accept) last_cmd <= {bus.motor1, bus.motor2};
         if (start || state != IDLE) idle_cnt <= '0;
         else                        idle_cnt <= idle_cnt + 1'b1;
      end
   end
`else
   assign bus.cmd_ready = ready_q;
   assign start         = accept;
   assign frame_src     = {bus.motor1, bus.motor2};
`endif

   spi_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .restart (start),
      .en      (state != IDLE),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next;
   end

   always_comb begin
      next     = state;
      bus.sck  = 1'b0;
      bus.load = 1'b0;
      bus.busy = 1'b1;
      unique case (state)
         IDLE: begin
            bus.busy = 1'b0;
            if (start) next = SETUP;
         end
         SETUP: begin
            bus.load = 1'b1;
            if (tick) next = HIGH;
         end
         HIGH: begin
            bus.load = 1'b1;
            bus.sck  = 1'b1;
            if (tick) next = last_bit ? TAIL : LOW;
         end
         LOW: begin
            bus.load = 1'b1;
            if (tick) next = HIGH;
         end
         TAIL: begin
            bus.load = 1'b1;
            if (tick) next = GAP;
         end
         GAP: begin
            if (tick) next = IDLE;
         end
         default: next = IDLE;
      endcase
      bus.sdi = bus.load && tx_sr[FRAME_W-1];
   end

   // sdo is captured on the clk edge that raises sck, matching the receiver's sample point
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_sr        <= '0;
         rx_sr        <= '0;
         bit_cnt      <= '0;
         ready_q      <= 1'b0;
         bus.rx_data  <= '0;
         bus.rx_valid <= 1'b0;
      end else begin
         ready_q      <= (state == IDLE) && !start;
         bus.rx_valid <= 1'b0;
         if (start) begin
            tx_sr   <= frame_src;
            rx_sr   <= '0;
            bit_cnt <= '0;
         end
         if (tick) begin
            case (state)
               SETUP, LOW: rx_sr <= {rx_sr[FRAME_W-2:0], bus.sdo};
               HIGH: begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (!last_bit) tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
               end
               TAIL: begin
                  bus.rx_data  <= rx_sr;
                  bus.rx_valid <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
